// File: rtl/wisc_isa_pkg.sv
// rtl/wisc_isa_pkg.sv - WISC ISA opcodes, field positions and IF/ID FSM encoding
package wisc_isa_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LD   = 5'b10001;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/ifid_hazard.sv
// rtl/ifid_hazard.sv - load-use hazard detect for the instruction held in IF/ID
module ifid_hazard
  import wisc_isa_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        valid,
  input  logic        idex_memread,
  input  logic        idex_valid,
  input  logic [2:0]  idex_rd,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        hazard
);

  logic [4:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       unused_low_bits;

  assign op              = opcode_of(instr);
  assign rs              = instr[RS_HI:RS_LO];
  assign rt              = instr[RT_HI:RT_LO];
  assign unused_low_bits = ^instr[RT_LO-1:0];

  // Rs is read by everything except control-free and immediate-load opcodes
  always_comb begin
    uses_rs = 1'b1;
    case (op)
      OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI: uses_rs = 1'b0;
      default:                               uses_rs = 1'b1;
    endcase
  end

  // Rt is read by R-format ALU ops, the 111xx group and the stores
  always_comb begin
    uses_rt = (op == 5'b11011) || (op == 5'b11010) || (op[4:2] == 3'b111) ||
              (op == OP_ST) || (op == OP_STU);
  end

  // A load in ID/EX feeding a source of the decode instruction must stall
  always_comb begin
    hazard = valid && idex_valid && idex_memread &&
             ((uses_rs && (rs == idex_rd)) || (uses_rt && (rt == idex_rd)));
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID register with flush, load-use stall and HALT; IF_ID_HAZARD_EN enables stalls
module if_id_stage
  import wisc_isa_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = wisc_isa_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] currPC_in,
  input  logic [15:0] nextPC_in,
  input  logic        branch_taken,
  input  logic        idex_memread,
  input  logic        idex_valid,
  input  logic [2:0]  idex_rd,
  output logic [15:0] instr_out,
  output logic [15:0] currPC_out,
  output logic [15:0] nextPC_out,
  output logic        valid_out,
  output logic        id_bubble,
  output logic        PCWriteEn,
  output logic        isNop,
  output logic [15:0] stallPC,
  output logic        halted,
  output logic [15:0] stall_count
);

`ifdef IF_ID_HAZARD_EN
  localparam logic HAZARD_EN = 1'b1;
`else
  localparam logic HAZARD_EN = 1'b0;
`endif

  logic [1:0] state;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard_raw;
  logic       unused_src_flags;
  logic       stall_now;
  logic       halt_now;

  ifid_hazard u_hazard (
    .instr        (instr_out),
    .valid        (valid_out),
    .idex_memread (idex_memread),
    .idex_valid   (idex_valid),
    .idex_rd      (idex_rd),
    .uses_rs      (uses_rs),
    .uses_rt      (uses_rt),
    .hazard       (hazard_raw)
  );

  // source-use flags are only observed by the hazard flag itself
  assign unused_src_flags = uses_rs ^ uses_rt;

  // A flush always wins over a stall or a halt; STALL ignores hazards
  always_comb begin
    stall_now = HAZARD_EN && hazard_raw && (state == ST_RUN) && !branch_taken;
    halt_now  = (state == ST_RUN) && valid_out &&
                (opcode_of(instr_out) == OP_HALT) && !branch_taken;
    PCWriteEn = (state != ST_HALT) && !stall_now;
    isNop     = stall_now;
    id_bubble = stall_now || (state == ST_HALT);
    stallPC   = nextPC_out;
  end

  // IF/ID capture, flush/stall/halt sequencing and the saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      instr_out   <= NOP_INSTR;
      currPC_out  <= 16'h0000;
      nextPC_out  <= 16'h0000;
      valid_out   <= 1'b0;
      halted      <= 1'b0;
      stall_count <= 16'h0000;
    end else if (state == ST_HALT) begin
      state <= ST_HALT;
    end else if (branch_taken) begin
      state      <= ST_RUN;
      instr_out  <= NOP_INSTR;
      currPC_out <= currPC_in;
      nextPC_out <= nextPC_in;
      valid_out  <= 1'b0;
    end else if (halt_now) begin
      state  <= ST_HALT;
      halted <= 1'b1;
    end else if (stall_now) begin
      state <= ST_STALL;
      if (stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end else begin
      state      <= ST_RUN;
      instr_out  <= instr_in;
      currPC_out <= currPC_in;
      nextPC_out <= nextPC_in;
      valid_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage (either IF_ID_HAZARD_EN build)
module tb_if_id_stage;

`ifdef IF_ID_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in, currPC_in, nextPC_in;
  logic        branch_taken, idex_memread, idex_valid;
  logic [2:0]  idex_rd;
  logic [15:0] instr_out, currPC_out, nextPC_out, stallPC, stall_count;
  logic        valid_out, id_bubble, PCWriteEn, isNop, halted;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] cpc;
    logic [15:0] npc;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          vecs = 0;
  int          errs = 0;
  logic [15:0] ref_cnt = 16'd0;
  logic [15:0] cur_npc = 16'd0;

  if_id_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .currPC_in(currPC_in),
    .nextPC_in(nextPC_in), .branch_taken(branch_taken), .idex_memread(idex_memread),
    .idex_valid(idex_valid), .idex_rd(idex_rd), .instr_out(instr_out),
    .currPC_out(currPC_out), .nextPC_out(nextPC_out), .valid_out(valid_out),
    .id_bubble(id_bubble), .PCWriteEn(PCWriteEn), .isNop(isNop), .stallPC(stallPC),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] pc, input logic br,
                       input logic mr, input logic [2:0] rd, input logic iv);
    instr_in     = i;
    currPC_in    = pc;
    nextPC_in    = pc + 16'd2;
    branch_taken = br;
    idex_memread = mr;
    idex_rd      = rd;
    idex_valid   = iv;
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] pc, input logic v);
    exp_t e;
    e.instr = i;
    e.cpc   = pc;
    e.npc   = pc + 16'd2;
    e.valid = v;
    e.cnt   = ref_cnt;
    sb.push_back(e);
  endtask

  task automatic chk_comb(input string tag, input logic pcw, input logic nop, input logic bub);
    chk({tag, ".pcw"}, 16'(PCWriteEn), 16'(pcw));
    chk({tag, ".isnop"}, 16'(isNop), 16'(nop));
    chk({tag, ".bubble"}, 16'(id_bubble), 16'(bub));
    chk({tag, ".stallpc"}, stallPC, cur_npc);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 16'(sb.size()), 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".instr"}, instr_out, e.instr);
      chk({tag, ".cpc"}, currPC_out, e.cpc);
      chk({tag, ".npc"}, nextPC_out, e.npc);
      chk({tag, ".valid"}, 16'(valid_out), 16'(e.valid));
      chk({tag, ".cnt"}, stall_count, e.cnt);
      cur_npc = e.npc;
    end
  endtask

  // one normal capture with no hazard inputs active
  task automatic pass(input string tag, input logic [15:0] i, input logic [15:0] pc);
    drive(i, pc, 1'b0, 1'b0, 3'd0, 1'b1);
    push(i, pc, 1'b1);
    tick(tag);
  endtask

  initial begin
    logic [15:0] ri, rp;

    rst = 1'b0;
    drive(16'hDB28, 16'h1234, 1'b1, 1'b1, 3'd3, 1'b1);
    repeat (3) @(posedge clk);
    drive(16'h0000, 16'h5678, 1'b0, 1'b1, 3'd3, 1'b1);
    chk("rst.instr", instr_out, 16'h0800);
    chk("rst.valid", 16'(valid_out), 16'd0);
    chk("rst.cpc", currPC_out, 16'h0000);
    chk("rst.cnt", stall_count, 16'h0000);
    chk("rst.halted", 16'(halted), 16'd0);
    chk_comb("rst", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // pass-through and random non-HALT stream
    drive(16'hD928, 16'h0010, 1'b0, 1'b0, 3'd0, 1'b1);
    chk_comb("pt.pre", 1'b1, 1'b0, 1'b0);
    push(16'hD928, 16'h0010, 1'b1);
    tick("pt");
    for (int k = 0; k < 8; k++) begin
      ri = {5'($urandom_range(1, 31)), 11'($urandom)};
      rp = {15'($urandom), 1'b0};
      drive(ri, rp, 1'b0, 1'b0, 3'($urandom), 1'b1);
      chk_comb("rnd.pre", 1'b1, 1'b0, 1'b0);
      push(ri, rp, 1'b1);
      tick("rnd");
    end

    // load-use on Rs: ADD r?,r3,r1 with a load to r3 in ID/EX
    pass("lu.ld", 16'hDB28, 16'h0020);
    drive(16'h4000, 16'h0022, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("lu.haz", ~HZ, HZ, HZ);
    ref_cnt = ref_cnt + 16'(HZ);
    push(HZ ? 16'hDB28 : 16'h4000, HZ ? 16'h0020 : 16'h0022, 1'b1);
    tick("lu.hold");
    drive(16'h4000, 16'h0022, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("lu.stall", 1'b1, 1'b0, 1'b0);
    push(16'h4000, 16'h0022, 1'b1);
    tick("lu.adv");

    // load-use on Rt: ST with Rt=5
    pass("rt.ld", 16'h80A0, 16'h0030);
    drive(16'h6000, 16'h0032, 1'b0, 1'b1, 3'd5, 1'b1);
    chk_comb("rt.haz", ~HZ, HZ, HZ);
    ref_cnt = ref_cnt + 16'(HZ);
    push(HZ ? 16'h80A0 : 16'h6000, HZ ? 16'h0030 : 16'h0032, 1'b1);
    tick("rt.hold");
    pass("rt.adv", 16'h6000, 16'h0032);

    // J never reads Rs; an invalid ID/EX slot never stalls
    pass("j.ld", 16'h2300, 16'h0040);
    drive(16'h6000, 16'h0042, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("j.nohaz", 1'b1, 1'b0, 1'b0);
    push(16'h6000, 16'h0042, 1'b1);
    tick("j.adv");
    pass("iv.ld", 16'hDB28, 16'h0044);
    drive(16'h6000, 16'h0046, 1'b0, 1'b1, 3'd3, 1'b0);
    chk_comb("iv.nohaz", 1'b1, 1'b0, 1'b0);
    push(16'h6000, 16'h0046, 1'b1);
    tick("iv.adv");

    // flush beats a stall
    pass("fl.ld", 16'hDB28, 16'h0050);
    drive(16'h4000, 16'h0052, 1'b1, 1'b1, 3'd3, 1'b1);
    chk_comb("fl.haz", 1'b1, 1'b0, 1'b0);
    push(16'h0800, 16'h0052, 1'b0);
    tick("fl.sq");

    // flush during STALL returns to RUN; next hazard stalls again
    pass("fs.ld", 16'hDB28, 16'h0060);
    drive(16'h4000, 16'h0062, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("fs.haz", ~HZ, HZ, HZ);
    ref_cnt = ref_cnt + 16'(HZ);
    push(HZ ? 16'hDB28 : 16'h4000, HZ ? 16'h0060 : 16'h0062, 1'b1);
    tick("fs.hold");
    drive(16'h4000, 16'h0062, 1'b1, 1'b1, 3'd3, 1'b1);
    chk_comb("fs.br", 1'b1, 1'b0, 1'b0);
    push(16'h0800, 16'h0062, 1'b0);
    tick("fs.sq");
    drive(16'hDB28, 16'h0070, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("fs.inv", 1'b1, 1'b0, 1'b0);
    push(16'hDB28, 16'h0070, 1'b1);
    tick("fs.ld2");
    drive(16'h4000, 16'h0072, 1'b0, 1'b1, 3'd3, 1'b1);
    chk_comb("fs.haz2", ~HZ, HZ, HZ);
    ref_cnt = ref_cnt + 16'(HZ);
    push(HZ ? 16'hDB28 : 16'h4000, HZ ? 16'h0070 : 16'h0072, 1'b1);
    tick("fs.hold2");
    pass("fs.adv", 16'h4000, 16'h0072);

    // reset in the middle of a stall
    pass("rs.ld", 16'hDB28, 16'h0080);
    drive(16'h4000, 16'h0082, 1'b0, 1'b1, 3'd3, 1'b1);
    ref_cnt = ref_cnt + 16'(HZ);
    push(HZ ? 16'hDB28 : 16'h4000, HZ ? 16'h0080 : 16'h0082, 1'b1);
    tick("rs.hold");
    rst = 1'b0;
    #1;
    ref_cnt = 16'd0;
    cur_npc = 16'd0;
    chk("rs.instr", instr_out, 16'h0800);
    chk("rs.valid", 16'(valid_out), 16'd0);
    chk("rs.cnt", stall_count, ref_cnt);
    chk_comb("rs", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pass("rs.run", 16'hDB28, 16'h0088);

    // squashed HALT never halts
    pass("sh.ld", 16'h0000, 16'h0090);
    drive(16'hDB28, 16'h0092, 1'b1, 1'b0, 3'd0, 1'b1);
    push(16'h0800, 16'h0092, 1'b0);
    tick("sh.sq");
    chk("sh.halted", 16'(halted), 16'd0);
    drive(16'h0000, 16'h0094, 1'b1, 1'b0, 3'd0, 1'b1);
    push(16'h0800, 16'h0094, 1'b0);
    tick("sh.sq2");
    pass("sh.run", 16'hDB28, 16'h0096);
    chk("sh.halted2", 16'(halted), 16'd0);

    // real HALT: sticky, PC frozen, bubbles, until reset
    pass("h.ld", 16'h0000, 16'h00A0);
    drive(16'hDB28, 16'h00A2, 1'b0, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("h.halted", 16'(halted), 16'd1);
    for (int k = 0; k < 10; k++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b1);
      chk("h.hold.halted", 16'(halted), 16'd1);
      chk("h.hold.pcw", 16'(PCWriteEn), 16'd0);
      chk("h.hold.bubble", 16'(id_bubble), 16'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("h.rst.halted", 16'(halted), 16'd0);
    chk("h.rst.pcw", 16'(PCWriteEn), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cur_npc = 16'd0;
    pass("h.run", 16'hD928, 16'h00B0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register with integrated load-use hazard control, sitting between the fetch stage and decode. It captures each fetched instruction with its PC and PC+2. It squashes the captured instruction on a taken branch. On a load-use hazard it stalls fetch for one cycle and hands decode a bubble. It latches HALT so the PC stops advancing.

## Interface

Parameters:
- `NOP_INSTR`, default 16'h0800: encoding driven on `instr_out` for bubbles and squashed slots (opcode 00001).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `instr_in` input 16: instruction from fetch memory.
- `currPC_in` input 16: PC of `instr_in`.
- `nextPC_in` input 16: PC+2 of `instr_in`.
- `branch_taken` input 1: branch/jump resolved taken this cycle; squash the fetched slot.
- `idex_memread` input 1: the instruction in ID/EX is a load.
- `idex_valid` input 1: the ID/EX slot holds a real instruction.
- `idex_rd` input 3: destination register of the ID/EX instruction.
- `instr_out` output 16: registered instruction to decode.
- `currPC_out` output 16: registered PC.
- `nextPC_out` output 16: registered PC+2.
- `valid_out` output 1: `instr_out` is a real instruction.
- `id_bubble` output 1: decode must inject a bubble into ID/EX this cycle.
- `PCWriteEn` output 1: PC register enable to fetch.
- `isNop` output 1: fetch must load `stallPC` instead of PC+2.
- `stallPC` output 16: PC fetch must re-present (`currPC_out` + 2, i.e. `nextPC_out`).
- `halted` output 1: HALT has reached decode; sticky until reset.
- `stall_count` output 16: number of hazard stall cycles, saturating.

## Operation

- State machine states:
  - RUN: normal operation.
  - STALL: one-cycle hazard hold.
  - HALT: terminal until reset.
- Source decode from `instr_out`: Rs = [10:8]; Rt = [7:5].
- Rs is used for all opcodes except 00000 (HALT), 00001 (NOP), 00100 (J), 00110 (JAL), 11000 (LBI).
- Rt is used for opcodes 11011, 11010, 111xx, 10000 (ST) and 10011 (STU).
- Hazard condition: `valid_out & idex_valid & idex_memread & ((uses_rs & rs==idex_rd) | (uses_rt & rt==idex_rd))`.
- RUN, hazard, no `branch_taken`:
  - Hold all IF/ID registers.
  - `PCWriteEn`=0, `isNop`=1, `id_bubble`=1.
  - Increment `stall_count`; go to STALL.
- STALL: hazard detection is suppressed. Next edge returns to RUN, and the held instruction advances.
- `branch_taken` (any non-HALT state):
  - Next edge loads `instr_out`=`NOP_INSTR` and `valid_out`=0. PCs are still captured.
  - Flush beats a hazard: no stall is taken and the count does not increment.
  - A STALL in progress is abandoned and the FSM returns to RUN.
- RUN with `valid_out` and opcode 00000, and no `branch_taken` the same cycle:
  - Go to HALT and set `halted`=1.
  - In HALT: `PCWriteEn`=0, registers hold, `id_bubble`=1.
- A squashed HALT (`valid_out`=0) never halts.
- `stall_count` saturates at 16'hFFFF. At saturation the hazard behaviour is unchanged.

## Timing

- All registers update on the rising `clk` edge.
- Reset values, applied asynchronously:
  - `instr_out`=`NOP_INSTR`.
  - `currPC_out`=`nextPC_out`=0.
  - `valid_out`=0, `halted`=0, `stall_count`=0, FSM=RUN.
- `PCWriteEn`, `isNop`, `id_bubble` and `stallPC` are combinational from state and registered outputs. Their post-reset values are 1, 0, 0 and 0.
- Latency: `instr_in` appears on `instr_out` one cycle later, or two cycles when a stall occurs.
- Reset asserted mid-STALL or mid-HALT returns to RUN immediately. No pending stall survives reset.
- Deasserting reset takes effect at the first edge after release.

## Configuration

- `IF_ID_HAZARD_EN` defined: load-use detection as above.
- Not defined: hazard condition tied to 0. STALL is unreachable, `stall_count` stays 0, and `isNop` is only ever 0. Software must schedule around loads.
- Flush and HALT behaviour are identical in both builds.

## Structure

- Shared package/include `wisc_isa_pkg`:
  - Opcode constants (HALT, NOP, J, JAL, LBI, ST, STU, LD) and `NOP_INSTR`.
  - Register-field bit positions.
  - FSM state encoding (RUN=2'd0, STALL=2'd1, HALT=2'd2).
- One sub-module, `ifid_hazard`: combinational; takes `instr_out`, `valid_out` and the ID/EX inputs; produces uses_rs, uses_rt and the hazard flag.

## Test plan

- Reset: hold `rst`=0 with arbitrary inputs → `instr_out`=16'h0800, `valid_out`=0, `PCWriteEn`=1, `stall_count`=0.
- Pass-through: `instr_in`=16'hD928 at `currPC_in`=16'h0010 → next cycle `instr_out`=16'hD928, `currPC_out`=16'h0010, `nextPC_out`=16'h0012, `valid_out`=1.
- Load-use: `instr_out` ADD with Rs=3, `idex_memread`=1, `idex_rd`=3, `idex_valid`=1 → one cycle of `PCWriteEn`=0, `isNop`=1, `id_bubble`=1, `stallPC`=`nextPC_out`; ADD advances the following cycle; `stall_count`=1.
- Flush beats stall: same hazard plus `branch_taken`=1 → no stall; next cycle `instr_out`=16'h0800, `valid_out`=0, `stall_count` unchanged.
- HALT: `instr_out`=16'h0000 valid → `halted`=1 and `PCWriteEn`=0 for 10 cycles. A squashed HALT does not halt. Asserting `rst` clears `halted`.
- Macro off: load-use stimulus → no stall; `stall_count` stays 0.
